// File: rtl/digit_reverse_reorder_pkg.sv
// Shared FFT constants and the base-4 digit-reversal helper used by the reorder
// block (and by the SDF stages feeding it).
package digit_reverse_reorder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_N     = 16;
    localparam int unsigned MAX_DIGITS    = 15;

    typedef enum logic {
        StIdle,
        StRead
    } rd_state_t;

    // Number of base-4 digits in an index over n points (n a power of 4).
    function automatic int unsigned log4(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
            if ((32'd1 << (2 * d)) == n) r = d;
        end
        return r;
    endfunction

    // Reverse the order of the low 'digits' base-4 digits of idx.
    function automatic int unsigned digit_rev(input int unsigned idx, input int unsigned digits);
        int unsigned rev;
        rev = 0;
        for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
            if (d < digits) rev = (rev << 2) | ((idx >> (2 * d)) & 32'd3);
        end
        return rev;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// Ping-pong sample store: two banks of Depth complex words, four write lanes and
// four asynchronous read lanes, each side choosing its bank independently.
module reorder_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned Depth = 16
) (
    input  logic                                clock,
    input  logic                                wr_en,
    input  logic                                wr_sel,
    input  logic [3:0][$clog2(Depth)-1:0]       wr_addr,
    input  logic [3:0][2*WIDTH-1:0]             wr_data,
    input  logic                                rd_sel,
    input  logic [3:0][$clog2(Depth)-1:0]       rd_addr,
    output logic [3:0][2*WIDTH-1:0]             rd_data
);

    localparam int unsigned AW = $clog2(Depth);

    logic [2*WIDTH-1:0] mem [2*Depth];

    // Write all four lanes of a beat; lane addresses within a beat never collide.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                mem[{wr_sel, wr_addr[l]}] <= wr_data[l];
            end
        end
    end

    // Combinational read so the top can register a beat one cycle after addressing it.
    always_comb begin
        rd_data = '0;
        for (int l = 0; l < 4; l++) begin
            rd_data[l] = mem[{rd_sel, rd_addr[l]}];
        end
    end

    logic [AW:0] unused_width_check;
    assign unused_width_check = '0;

endmodule

// File: rtl/digit_reverse_reorder.sv
// Converts the 4-lane digit-reversed FFT stream into natural order. Input beats
// are scattered into one bank at digit-reversed addresses; once a frame is
// complete the read side streams that bank out linearly while the next frame
// fills the other bank.
module digit_reverse_reorder
    import digit_reverse_reorder_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned Num_of_samples = DEFAULT_N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real_0,
    input  logic [WIDTH-1:0] input_real_1,
    input  logic [WIDTH-1:0] input_real_2,
    input  logic [WIDTH-1:0] input_real_3,
    input  logic [WIDTH-1:0] input_imag_0,
    input  logic [WIDTH-1:0] input_imag_1,
    input  logic [WIDTH-1:0] input_imag_2,
    input  logic [WIDTH-1:0] input_imag_3,
    output logic             output_en,
    output logic [WIDTH-1:0] output_real_0,
    output logic [WIDTH-1:0] output_real_1,
    output logic [WIDTH-1:0] output_real_2,
    output logic [WIDTH-1:0] output_real_3,
    output logic [WIDTH-1:0] output_imag_0,
    output logic [WIDTH-1:0] output_imag_1,
    output logic [WIDTH-1:0] output_imag_2,
    output logic [WIDTH-1:0] output_imag_3,
    output logic             output_last
);

    localparam int unsigned   AW        = $clog2(Num_of_samples);
    localparam int unsigned   CW        = AW - 2;
    localparam int unsigned   DIGITS    = log4(Num_of_samples);
    localparam logic [CW-1:0] LAST_BEAT = CW'(Num_of_samples / 4 - 1);

    logic [3:0][2*WIDTH-1:0] wr_data;
    logic [3:0][2*WIDTH-1:0] rd_data;
    logic [3:0][AW-1:0]      wr_addr;
    logic [3:0][AW-1:0]      rd_addr;

    logic [CW-1:0] wr_cnt_q;
    logic          wr_bank_q;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    rd_state_t     state_q, state_d;

    logic frame_done;
    logic rd_load;
    logic rd_last;

    logic [3:0][WIDTH-1:0] out_real_q;
    logic [3:0][WIDTH-1:0] out_imag_q;
    logic                  out_en_q;
    logic                  out_last_q;

    assign wr_data[0] = {input_real_0, input_imag_0};
    assign wr_data[1] = {input_real_1, input_imag_1};
    assign wr_data[2] = {input_real_2, input_imag_2};
    assign wr_data[3] = {input_real_3, input_imag_3};

    assign frame_done = input_en && (wr_cnt_q == LAST_BEAT);

    // Lane j of beat k is linear index 4k+j; scatter it to its digit-reversed slot
    // and read back linearly on the other side.
    always_comb begin
        wr_addr = '0;
        rd_addr = '0;
        for (int j = 0; j < 4; j++) begin
            wr_addr[j] = AW'(digit_rev(32'({wr_cnt_q, 2'(j)}), DIGITS));
            rd_addr[j] = {rd_cnt_q, 2'(j)};
        end
    end

    reorder_bank #(
        .WIDTH (WIDTH),
        .Depth (Num_of_samples)
    ) u_bank (
        .clock   (clock),
        .wr_en   (input_en),
        .wr_sel  (wr_bank_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_sel  (rd_bank_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Write beat counter and bank pointer; both only move on valid input beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (input_en) begin
            wr_cnt_q <= frame_done ? '0 : wr_cnt_q + 1'b1;
            if (frame_done) wr_bank_q <= ~wr_bank_q;
        end
    end

    // Read FSM state, beat counter and selected bank.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Start a read burst on the bank just filled; chain straight into the next
    // frame when it completes on the same edge as our final beat.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_load   = 1'b0;
        rd_last   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_done) begin
                    state_d   = StRead;
                    rd_cnt_d  = '0;
                    rd_bank_d = wr_bank_q;
                end
            end
            StRead: begin
                rd_load  = 1'b1;
                rd_last  = (rd_cnt_q == LAST_BEAT);
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_last) begin
                    if (frame_done) begin
                        rd_cnt_d  = '0;
                        rd_bank_d = wr_bank_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output registers: data loads only on read beats and otherwise holds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_en_q   <= 1'b0;
            out_last_q <= 1'b0;
            out_real_q <= '0;
            out_imag_q <= '0;
        end else begin
            out_en_q   <= rd_load;
            out_last_q <= rd_load && rd_last;
            if (rd_load) begin
                for (int j = 0; j < 4; j++) begin
                    out_real_q[j] <= rd_data[j][2*WIDTH-1:WIDTH];
                    out_imag_q[j] <= rd_data[j][WIDTH-1:0];
                end
            end
        end
    end

    assign output_en     = out_en_q;
    assign output_last   = out_last_q;
    assign output_real_0 = out_real_q[0];
    assign output_real_1 = out_real_q[1];
    assign output_real_2 = out_real_q[2];
    assign output_real_3 = out_real_q[3];
    assign output_imag_0 = out_imag_q[0];
    assign output_imag_1 = out_imag_q[1];
    assign output_imag_2 = out_imag_q[2];
    assign output_imag_3 = out_imag_q[3];

endmodule

// File: tb/tb_digit_reverse_reorder.sv
// Bench for digit_reverse_reorder: N=16 instance checked through a scoreboard
// queue and hand timing checks, N=64 instance checked against a reversal table.
module tb_digit_reverse_reorder;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [3:0][15:0] in_v;
        logic [3:0][15:0] out_v;
        logic             last;
    } vec_t;

    typedef struct packed {
        logic [3:0][W-1:0] re;
        logic [3:0][W-1:0] im;
        logic              last;
    } exp_t;

    typedef struct packed {
        logic [7:0]       beat;
        logic [3:0][15:0] lanes;
    } vec64_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t   q16[$];
    int     out_cyc[$];
    vec_t   vec16[4];
    vec64_t vec64[3];
    exp_t   mon_e;

    logic [3:0][W-1:0] cap64_re[16];
    logic [3:0][W-1:0] cap64_im[16];
    int                cnt64 = 0;

    logic              en16 = 1'b0;
    logic [3:0][W-1:0] in_re16 = '0;
    logic [3:0][W-1:0] in_im16 = '0;
    logic [3:0][W-1:0] out_re16;
    logic [3:0][W-1:0] out_im16;
    logic              oen16;
    logic              olast16;

    logic              en64 = 1'b0;
    logic [3:0][W-1:0] in_re64 = '0;
    logic [3:0][W-1:0] in_im64 = '0;
    logic [3:0][W-1:0] out_re64;
    logic [3:0][W-1:0] out_im64;
    logic              oen64;
    logic              olast64;

    digit_reverse_reorder #(.WIDTH(W), .Num_of_samples(16)) dut16 (
        .clock         (clock),
        .reset         (reset),
        .input_en      (en16),
        .input_real_0  (in_re16[0]),
        .input_real_1  (in_re16[1]),
        .input_real_2  (in_re16[2]),
        .input_real_3  (in_re16[3]),
        .input_imag_0  (in_im16[0]),
        .input_imag_1  (in_im16[1]),
        .input_imag_2  (in_im16[2]),
        .input_imag_3  (in_im16[3]),
        .output_en     (oen16),
        .output_real_0 (out_re16[0]),
        .output_real_1 (out_re16[1]),
        .output_real_2 (out_re16[2]),
        .output_real_3 (out_re16[3]),
        .output_imag_0 (out_im16[0]),
        .output_imag_1 (out_im16[1]),
        .output_imag_2 (out_im16[2]),
        .output_imag_3 (out_im16[3]),
        .output_last   (olast16)
    );

    digit_reverse_reorder #(.WIDTH(W), .Num_of_samples(64)) dut64 (
        .clock         (clock),
        .reset         (reset),
        .input_en      (en64),
        .input_real_0  (in_re64[0]),
        .input_real_1  (in_re64[1]),
        .input_real_2  (in_re64[2]),
        .input_real_3  (in_re64[3]),
        .input_imag_0  (in_im64[0]),
        .input_imag_1  (in_im64[1]),
        .input_imag_2  (in_im64[2]),
        .input_imag_3  (in_im64[3]),
        .output_en     (oen64),
        .output_real_0 (out_re64[0]),
        .output_real_1 (out_re64[1]),
        .output_real_2 (out_re64[2]),
        .output_real_3 (out_re64[3]),
        .output_imag_0 (out_im64[0]),
        .output_imag_1 (out_im64[1]),
        .output_imag_2 (out_im64[2]),
        .output_imag_3 (out_im64[3]),
        .output_last   (olast64)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard for the N=16 instance.
    always @(negedge clock) begin
        if (reset && oen16) begin
            out_cyc.push_back(cyc);
            if (q16.size() == 0) begin
                check("unexpected_out16", 128'(out_re16[0]), 128'hDEAD);
            end else begin
                mon_e = q16.pop_front();
                check("out16_real", out_re16, mon_e.re);
                check("out16_imag", out_im16, mon_e.im);
                check("out16_last", 128'(olast16), 128'(mon_e.last));
            end
        end
    end

    // Capture for the N=64 instance.
    always @(negedge clock) begin
        if (reset && oen64) begin
            if (cnt64 < 16) begin
                cap64_re[cnt64] = out_re64;
                cap64_im[cnt64] = out_im64;
                check("out64_last", 128'(olast64), 128'(cnt64 == 15));
            end else begin
                check("extra_out64", 128'(cnt64), 128'(16));
            end
            cnt64++;
        end
    end

    task automatic drive16(input logic [3:0][15:0] lanes, input int unsigned base);
        en16 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_re16[j] = W'(base + lanes[j]);
            in_im16[j] = W'(0) - W'(base + lanes[j]);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame16(input int unsigned base);
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            for (int j = 0; j < 4; j++) begin
                e.re[j] = W'(base + vec16[m].out_v[j]);
                e.im[j] = W'(0) - W'(base + vec16[m].out_v[j]);
            end
            e.last = vec16[m].last;
            q16.push_back(e);
        end
    endtask

    task automatic send_frame16(input int unsigned base);
        for (int m = 0; m < 4; m++) begin
            if (m == 3) push_frame16(base);
            drive16(vec16[m].in_v, base);
        end
    endtask

    task automatic drain16(input string name);
        en16 = 1'b0;
        for (int t = 0; t < 100 && q16.size() != 0; t++) @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
        check(name, 128'(q16.size()), 128'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [3:0][W-1:0] hold_exp;
        logic [3:0][W-1:0] x;
        int idx;
        int rev;

        vec16[0] = '{in_v: {16'd3, 16'd2, 16'd1, 16'd0},
                     out_v: {16'd12, 16'd8, 16'd4, 16'd0}, last: 1'b0};
        vec16[1] = '{in_v: {16'd7, 16'd6, 16'd5, 16'd4},
                     out_v: {16'd13, 16'd9, 16'd5, 16'd1}, last: 1'b0};
        vec16[2] = '{in_v: {16'd11, 16'd10, 16'd9, 16'd8},
                     out_v: {16'd14, 16'd10, 16'd6, 16'd2}, last: 1'b0};
        vec16[3] = '{in_v: {16'd15, 16'd14, 16'd13, 16'd12},
                     out_v: {16'd15, 16'd11, 16'd7, 16'd3}, last: 1'b1};
        vec64[0] = '{beat: 8'd0, lanes: {16'd48, 16'd32, 16'd16, 16'd0}};
        vec64[1] = '{beat: 8'd1, lanes: {16'd52, 16'd36, 16'd20, 16'd4}};
        vec64[2] = '{beat: 8'd4, lanes: {16'd49, 16'd33, 16'd17, 16'd1}};

        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_en_last", {oen16, olast16, oen64, olast64}, 128'(0));
        check("reset_data16", out_re16 | out_im16, 128'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single frame with latency and hold checks
        send_frame16(0);
        en16 = 1'b0;
        check("lat_edge_T", 128'(oen16), 128'(0));
        @(posedge clock);
        #1;
        check("lat_edge_T1", 128'(oen16), 128'(1));
        repeat (3) @(posedge clock);
        #1;
        check("last_on_beat3", 128'({oen16, olast16}), 128'(2'b11));
        @(posedge clock);
        #1;
        check("idle_after_burst", 128'({oen16, olast16}), 128'(0));
        for (int j = 0; j < 4; j++) hold_exp[j] = W'(vec16[3].out_v[j]);
        check("data_hold", out_re16, hold_exp);
        drain16("drain_single");

        // Three back-to-back frames
        out_cyc.delete();
        for (int f = 0; f < 3; f++) send_frame16(100 * f);
        drain16("drain_b2b");
        check("b2b_beats", 128'(out_cyc.size()), 128'(12));
        check("b2b_span", 128'((out_cyc.size() == 12) ? out_cyc[11] - out_cyc[0] : -1), 128'(11));

        // Gapped input 1,0,0,1,...
        out_cyc.delete();
        for (int m = 0; m < 4; m++) begin
            if (m == 3) push_frame16(0);
            drive16(vec16[m].in_v, 0);
            if (m < 3) begin
                en16 = 1'b0;
                repeat (2) @(posedge clock);
                #1;
            end
        end
        drain16("drain_gapped");
        check("gap_beats", 128'(out_cyc.size()), 128'(4));
        check("gap_span", 128'((out_cyc.size() == 4) ? out_cyc[3] - out_cyc[0] : -1), 128'(3));

        // Reset after a partial frame, then a full frame of 50..65
        for (int m = 0; m < 3; m++) drive16(vec16[m].in_v, 300);
        en16 = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_clear_ctl", 128'({oen16, olast16}), 128'(0));
        check("async_clear_data", out_re16 | out_im16, 128'(0));
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        send_frame16(50);
        drain16("drain_after_reset");

        // N=64 frame, lanes carry the linear index
        for (int k = 0; k < 16; k++) begin
            en64 = 1'b1;
            for (int j = 0; j < 4; j++) begin
                in_re64[j] = W'(4 * k + j);
                in_im64[j] = W'(0) - W'(4 * k + j);
            end
            @(posedge clock);
            #1;
        end
        en64 = 1'b0;
        for (int t = 0; t < 100 && cnt64 < 16; t++) @(posedge clock);
        #1;
        check("n64_count", 128'(cnt64), 128'(16));
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++) x[j] = W'(vec64[r].lanes[j]);
            check("n64_table", cap64_re[vec64[r].beat], x);
        end
        for (int m = 0; m < 16; m++) begin
            for (int j = 0; j < 4; j++) begin
                idx = 4 * m + j;
                rev = (idx % 4) * 16 + ((idx / 4) % 4) * 4 + idx / 16;
                x[j] = W'(rev);
            end
            check("n64_real", cap64_re[m], x);
            for (int j = 0; j < 4; j++) x[j] = W'(0) - x[j];
            check("n64_imag", cap64_im[m], x);
        end

        repeat (4) @(posedge clock);
        #1;
        check("final_queue_empty", 128'(q16.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
